// File: rtl/pl_regfile_mp_if.sv
// Register-file access bundle: write, trigger and clear controls in; read-port and debug data plus ClrBusy out.
interface pl_regfile_mp_if #(
    parameter int WAD = 5,
    parameter int WD  = 32,
    parameter int NRD = 2
);
    logic               RegWrite;
    logic [WAD-1:0]     AdInReg;
    logic [WD-1:0]      DInReg;
    logic [NRD*WAD-1:0] AdOutReg;
    logic [NRD*WD-1:0]  DOutReg;
    logic               Trigger;
    logic               ClrReq;
    logic               ClrBusy;
    logic [WAD-1:0]     AdDbg;
    logic [WD-1:0]      DDbg;

    modport master (
        output RegWrite, AdInReg, DInReg, AdOutReg, Trigger, ClrReq, AdDbg,
        input  DOutReg, ClrBusy, DDbg
    );

    modport slave (
        input  RegWrite, AdInReg, DInReg, AdOutReg, Trigger, ClrReq, AdDbg,
        output DOutReg, ClrBusy, DDbg
    );
endinterface

// File: rtl/pl_regfile_mp.sv
// Multi-port register file, x0 = 0, Trigger load, soft-clear sequencer; reads 0-cycle, writes at the edge.
// No backpressure: ClrBusy marks 2**WAD-1 clear cycles (writes dropped, reads 0). Option: REGFILE_BYPASS_EN.
module pl_regfile_mp #(
    parameter int WAD      = 5,
    parameter int WD       = 32,
    parameter int NRD      = 2,
    parameter int TRIG_REG = 5,
    parameter int TRIG_VAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pl_regfile_mp_if.slave   rf
);
    localparam int             DEPTH    = 1 << WAD;
    localparam logic [WAD-1:0] LAST_AD  = WAD'(DEPTH - 1);
    localparam logic [WAD-1:0] TRIG_AD  = WAD'(TRIG_REG);
    localparam logic [WD-1:0]  TRIG_DAT = WD'(TRIG_VAL);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state_q, state_d;
    logic [WAD-1:0] cnt_q, cnt_d;
    logic [WD-1:0]  mem_q [DEPTH];
    logic [WD-1:0]  mem_d [DEPTH];
    logic           trig_we;
    logic           user_we;
    logic [WAD-1:0] rd_ad  [NRD+1];
    logic [WD-1:0]  rd_dat [NRD+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_we = 1'b0;
        user_we = 1'b0;
        if (state_q == CLEAR) begin
            // Counter parks at the last address instead of wrapping.
            if (cnt_q == LAST_AD) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            trig_we = rf.Trigger && (TRIG_AD != '0);
            user_we = rf.RegWrite && (rf.AdInReg != '0) &&
                      !(rf.Trigger && (rf.AdInReg == TRIG_AD));
            if (rf.ClrReq) begin
                state_d = CLEAR;
                cnt_d   = WAD'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= WAD'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (state_q == CLEAR) begin
            mem_d[cnt_q] = '0;
        end
        if (user_we) begin
            mem_d[rf.AdInReg] = rf.DInReg;
        end
        if (trig_we) begin
            mem_d[TRIG_AD] = TRIG_DAT;
        end
    end

    // Storage is deliberately unreset; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_ad[k] = rf.AdOutReg[k*WAD +: WAD];
        end
        rd_ad[NRD] = rf.AdDbg;
    end

    // Slot NRD is the debug port; it shares the read path of the normal ports.
    always_comb begin
        for (int k = 0; k <= NRD; k++) begin
            rd_dat[k] = '0;
            if ((state_q == IDLE) && (rd_ad[k] != '0)) begin
                rd_dat[k] = mem_q[rd_ad[k]];
`ifdef REGFILE_BYPASS_EN
                if (trig_we && (rd_ad[k] == TRIG_AD)) begin
                    rd_dat[k] = TRIG_DAT;
                end else if (user_we && (rd_ad[k] == rf.AdInReg)) begin
                    rd_dat[k] = rf.DInReg;
                end
`endif
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rf.DOutReg[k*WD +: WD] = rd_dat[k];
    end

    assign rf.DDbg    = rd_dat[NRD];
    assign rf.ClrBusy = (state_q == CLEAR);
endmodule

// File: tb/tb_pl_regfile_mp.sv
// Bench for pl_regfile_mp: random traffic against an array-based model plus directed scenarios.
module tb_pl_regfile_mp;
    localparam int WAD      = 5;
    localparam int WD       = 32;
    localparam int NRD      = 2;
    localparam int TRIG_REG = 5;
    localparam int TRIG_VAL = 1;
    localparam int DEPTH    = 32;
    localparam int NCLR     = 31;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pl_regfile_mp_if #(.WAD(WAD), .WD(WD), .NRD(NRD)) rf ();

    pl_regfile_mp #(
        .WAD(WAD), .WD(WD), .NRD(NRD), .TRIG_REG(TRIG_REG), .TRIG_VAL(TRIG_VAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    int checks = 0;
    int errors = 0;

    // Model: register contents as seen after the clear completes, plus cycles of clear still to go.
    logic [WD-1:0] mdl [DEPTH];
    int            clr_left = NCLR;

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    end

    task automatic chk(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WD-1:0] exp_rd(input logic [WAD-1:0] a);
        if (!rst_n || clr_left > 0 || a == '0) return '0;
        if (BYP && rf.Trigger && a == WAD'(TRIG_REG)) return WD'(TRIG_VAL);
        if (BYP && rf.RegWrite && a == rf.AdInReg) return rf.DInReg;
        return mdl[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_left = NCLR;
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else begin
            if (rf.Trigger) mdl[TRIG_REG] = WD'(TRIG_VAL);
            if (rf.RegWrite && rf.AdInReg != '0 && !(rf.Trigger && rf.AdInReg == WAD'(TRIG_REG)))
                mdl[rf.AdInReg] = rf.DInReg;
            if (rf.ClrReq) begin
                clr_left = NCLR;
                for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", WD'(rf.ClrBusy), WD'((!rst_n || clr_left > 0) ? 1 : 0));
        for (int k = 0; k < NRD; k++)
            chk($sformatf("rd%0d", k), rf.DOutReg[k*WD +: WD], exp_rd(rf.AdOutReg[k*WAD +: WAD]));
        chk("dbg", rf.DDbg, exp_rd(rf.AdDbg));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rf.RegWrite = 1'b0;
        rf.Trigger  = 1'b0;
        rf.ClrReq   = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int ad);
        rf.AdOutReg = {WAD'(a1), WAD'(a0)};
        rf.AdDbg    = WAD'(ad);
    endtask

    task automatic wr(input int a, input logic [WD-1:0] d, input bit trig);
        rf.RegWrite = 1'b1;
        rf.AdInReg  = WAD'(a);
        rf.DInReg   = d;
        rf.Trigger  = trig;
        step();
        quiet();
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!rf.ClrBusy) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk(name, WD'(n), WD'(NCLR));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        quiet();
        rf.AdInReg = '0;
        rf.DInReg  = '0;
        set_rd(0, 0, 0);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        count_busy("reset_clear_len");

        // Write then read on port 1 and debug; x0 stays zero.
        wr(7, 32'hDEADBEEF, 1'b0);
        set_rd(0, 7, 7);
        @(negedge clk);
        chk("x7_port1", rf.DOutReg[WD +: WD], 32'hDEADBEEF);
        chk("x7_dbg", rf.DDbg, 32'hDEADBEEF);
        step();
        wr(0, 32'h5, 1'b0);
        set_rd(0, 0, 0);
        @(negedge clk);
        chk("x0_zero", rf.DOutReg[0 +: WD], 32'h0);
        step();

        // Trigger precedence over a colliding write, coexistence with another write.
        wr(5, 32'h1234, 1'b1);
        set_rd(5, 0, 5);
        @(negedge clk);
        chk("trig_wins", rf.DOutReg[0 +: WD], 32'h1);
        step();
        wr(6, 32'h1234, 1'b1);
        set_rd(5, 6, 6);
        @(negedge clk);
        chk("trig_x5", rf.DOutReg[0 +: WD], 32'h1);
        chk("trig_x6", rf.DOutReg[WD +: WD], 32'h1234);
        step();

        // Same-cycle read of the register being written.
        wr(9, 32'h11, 1'b0);
        set_rd(9, 0, 9);
        rf.RegWrite = 1'b1;
        rf.AdInReg  = WAD'(9);
        rf.DInReg   = 32'hA5;
        @(negedge clk);
        chk("bypass_port0", rf.DOutReg[0 +: WD], BYP ? 32'hA5 : 32'h11);
        chk("bypass_dbg", rf.DDbg, BYP ? 32'hA5 : 32'h11);
        step();
        quiet();
        @(negedge clk);
        chk("x9_after", rf.DOutReg[0 +: WD], 32'hA5);
        step();

        // Fill, soft clear, write attempted mid-clear.
        for (int i = 1; i < DEPTH; i++) wr(i, WD'(i), 1'b0);
        set_rd(3, 31, 17);
        @(negedge clk);
        chk("fill_x3", rf.DOutReg[0 +: WD], 32'd3);
        chk("fill_x31", rf.DOutReg[WD +: WD], 32'd31);
        step();
        rf.ClrReq = 1'b1;
        step();
        rf.ClrReq = 1'b0;
        repeat (9) step();
        wr(3, 32'h9, 1'b0);
        begin
            int n = 0;
            while (rf.ClrBusy && n < 100) begin step(); n++; end
            chk("clr_done", WD'(rf.ClrBusy), 32'h0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i, DEPTH - 1 - i, i);
            @(negedge clk);
            chk($sformatf("cleared_x%0d", i), rf.DDbg, 32'h0);
            step();
        end

        // Reset in the middle of a clear restarts the sequence.
        rf.ClrReq = 1'b1;
        step();
        rf.ClrReq = 1'b0;
        repeat (14) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        count_busy("reset_mid_clear_len");

        for (int c = 0; c < 3000; c++) begin
            rf.RegWrite = 1'($urandom_range(0, 1));
            rf.AdInReg  = ($urandom_range(0, 3) == 0) ? WAD'(TRIG_REG) : WAD'($urandom_range(0, DEPTH - 1));
            rf.DInReg   = $urandom;
            rf.Trigger  = ($urandom_range(0, 7) == 0);
            rf.ClrReq   = ($urandom_range(0, 149) == 0);
            set_rd(($urandom_range(0, 2) == 0) ? int'(rf.AdInReg) : int'($urandom_range(0, DEPTH - 1)),
                   ($urandom_range(0, 3) == 0) ? TRIG_REG : int'($urandom_range(0, DEPTH - 1)),
                   ($urandom_range(0, 2) == 0) ? int'(rf.AdInReg) : int'($urandom_range(0, DEPTH - 1)));
            step();
        end
        quiet();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
